instruction_fetch: RTL and testbench

Fetch stage between the program counter and decode/execute. Drives the 13-bit address bus of the asynchronous-read instruction memory, captures the returned 16-bit instruction word, and buffers it with its address in a small prefetch FIFO. Downstream pulls instructions through a valid/ready handshake. Unconditional `jmp` is resolved and removed here; taken `jez` is handled by a redirect from execute.

---
 rtl/instruction_fetch.sv | 113 +++++++++++
 tb/tb_instruction_fetch.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: drives the PC onto an asynchronous-read instruction
// memory and buffers {pc, word} pairs in a small prefetch FIFO for decode.
// Unconditional jmp words are folded here and never reach the FIFO.
// A redirect from execute (taken jez) flushes the FIFO and reloads the PC.
module instruction_fetch #(
  parameter int AW    = 13,
  parameter int DW    = 16,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc
);

  // DEPTH is a power of two (2 or 4), so pointers wrap naturally.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0]    OP_JMP  = 3'b100;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] fifo_pc_q   [DEPTH];
  logic [DW-1:0] fifo_word_q [DEPTH];

  logic pop;
  logic space;
  logic is_jmp;
  logic fetch;
  logic push;

  // Handshake and fetch decisions for this cycle.
  always_comb begin
    pop    = (count_q != '0) && inst_ready;
    space  = (count_q < DEPTH_C) || pop;
    is_jmp = (imem_data[DW-1:DW-3] == OP_JMP);
    fetch  = space && !redirect_valid;
    push   = fetch && !is_jmp;
  end

  // Next-state for PC, pointers and occupancy; redirect overrides everything.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      // A same-cycle pop is simply absorbed by the flush.
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fetch) begin
        // jmp is folded: the target becomes the next fetch address.
        pc_d = is_jmp ? imem_data[AW-1:0] : pc_q + AW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO payload storage; contents are only observed when count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= pc_q;
      fifo_word_q[wr_ptr_q] <= imem_data;
    end
  end

  // Head presentation, forced to zero while the FIFO is empty.
  always_comb begin
    imem_addr  = pc_q;
    inst_valid = (count_q != '0);
    inst_data  = inst_valid ? fifo_word_q[rd_ptr_q] : '0;
    inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus a randomized run
// against a queue-based model of the fetch rules.
module tb_instruction_fetch;
  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [DW-1:0] inst_data;
  logic [AW-1:0] inst_pc;

  logic [DW-1:0] mem [0:8191];
  logic [DW-1:0] exp_w [4] = '{16'hC00A, 16'h2000, 16'hC005, 16'h2001};

  // Reference model state: queue of {pc, word} and the fetch address.
  logic [AW+DW-1:0] mq [$];
  logic [AW-1:0]    m_pc;

  int n_checks = 0;
  int n_pass   = 0;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  instruction_fetch #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  task automatic fill_mem(input int jmp_pct);
    logic [DW-1:0] w;
    for (int i = 0; i < 8192; i++) begin
      w = DW'($urandom);
      if (w[15:13] == 3'b100 && $urandom_range(99) >= jmp_pct) w[15:13] = 3'b000;
      mem[i] = w;
    end
  endtask

  task automatic set_fixed();
    mem[0] = 16'hC00A; mem[1] = 16'h2000; mem[2] = 16'hC005; mem[3] = 16'h2001;
    mem[4] = 16'h0000; mem[10] = 16'hA000; mem[11] = 16'h8004; mem[8191] = 16'h0000;
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic model_step();
    int sz;
    bit mpop;
    logic [DW-1:0] w;
    sz = mq.size();
    mpop = (sz > 0) && inst_ready;
    if (!rst_n) begin
      mq.delete();
      m_pc = '0;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc;
    end else begin
      if (mpop) mq.delete(0);
      if (sz < DEPTH || mpop) begin
        w = mem[m_pc];
        if (w[15:13] == 3'b100) begin
          m_pc = w[12:0];
        end else begin
          mq.push_back({m_pc, w});
          m_pc = m_pc + 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    mq.delete();
    m_pc = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else n_pass++;
    n_checks++;
    if (inst_data !== '0) $display("FAIL reset_data: got %h want 0000", inst_data); else n_pass++;
    n_checks++;
    if (inst_pc !== '0) $display("FAIL reset_pc: got %0d want 0", inst_pc); else n_pass++;
    n_checks++;
    if (imem_addr !== '0) $display("FAIL reset_addr: got %0d want 0", imem_addr); else n_pass++;
  endtask

  task automatic test_stream();
    apply_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({inst_valid, inst_pc, inst_data} !== {1'b1, AW'(i), exp_w[i]})
        $display("FAIL stream_%0d: got v=%b pc=%0d d=%h want v=1 pc=%0d d=%h",
                 i, inst_valid, inst_pc, inst_data, i, exp_w[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    inst_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_checks++;
      if ({inst_valid, inst_pc, inst_data} !== {1'b1, 13'd0, 16'hC00A})
        $display("FAIL bp_head_%0d: got v=%b pc=%0d d=%h want v=1 pc=0 d=c00a",
                 c, inst_valid, inst_pc, inst_data);
      else n_pass++;
      if (c >= 2) begin
        n_checks++;
        if (imem_addr !== 13'd2) $display("FAIL bp_addr_%0d: got %0d want 2", c, imem_addr);
        else n_pass++;
      end
    end
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({inst_valid, inst_pc, inst_data} !== {1'b1, AW'(k), exp_w[k]})
        $display("FAIL bp_drain_%0d: got v=%b pc=%0d d=%h want v=1 pc=%0d d=%h",
                 k, inst_valid, inst_pc, inst_data, k, exp_w[k]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_jmp_fold();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 13'd10;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if ({inst_valid, imem_addr} !== {1'b0, 13'd10})
      $display("FAIL jmp_start: got v=%b addr=%0d want v=0 addr=10", inst_valid, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if ({inst_valid, inst_pc, inst_data, imem_addr} !== {1'b1, 13'd10, 16'hA000, 13'd11})
      $display("FAIL jmp_head10: got v=%b pc=%0d d=%h addr=%0d want v=1 pc=10 d=a000 addr=11",
               inst_valid, inst_pc, inst_data, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if ({inst_valid, inst_data, imem_addr} !== {1'b0, 16'h0000, 13'd4})
      $display("FAIL jmp_bubble: got v=%b d=%h addr=%0d want v=0 d=0000 addr=4",
               inst_valid, inst_data, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if ({inst_valid, inst_pc, inst_data} !== {1'b1, 13'd4, 16'h0000})
      $display("FAIL jmp_target: got v=%b pc=%0d d=%h want v=1 pc=4 d=0000",
               inst_valid, inst_pc, inst_data);
    else n_pass++;
  endtask

  task automatic test_redirect_flush();
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 13'd10;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if ({inst_valid, inst_pc, inst_data} !== {1'b1, 13'd10, 16'hA000})
      $display("FAIL flush_pre: got v=%b pc=%0d d=%h want v=1 pc=10 d=a000",
               inst_valid, inst_pc, inst_data);
    else n_pass++;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 13'd0;
    inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if ({inst_valid, imem_addr} !== {1'b0, 13'd0})
      $display("FAIL flush_empty: got v=%b addr=%0d want v=0 addr=0", inst_valid, imem_addr);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({inst_valid, inst_pc, inst_data} !== {1'b1, AW'(k), exp_w[k]})
        $display("FAIL flush_after_%0d: got v=%b pc=%0d d=%h want v=1 pc=%0d d=%h",
                 k, inst_valid, inst_pc, inst_data, k, exp_w[k]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 13'd8191;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if ({inst_valid, imem_addr} !== {1'b0, 13'd8191})
      $display("FAIL wrap_addr: got v=%b addr=%0d want v=0 addr=8191", inst_valid, imem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if ({inst_valid, inst_pc, inst_data, imem_addr} !== {1'b1, 13'd8191, 16'h0000, 13'd0})
      $display("FAIL wrap_head: got v=%b pc=%0d d=%h addr=%0d want v=1 pc=8191 d=0000 addr=0",
               inst_valid, inst_pc, inst_data, imem_addr);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    inst_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if (inst_valid !== 1'b1) $display("FAIL arst_full: got v=%b want 1", inst_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({inst_valid, inst_pc, inst_data, imem_addr} !== '0)
      $display("FAIL arst_zero: got v=%b pc=%0d d=%h addr=%0d want all 0",
               inst_valid, inst_pc, inst_data, imem_addr);
    else n_pass++;
    mq.delete();
    m_pc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if ({inst_valid, inst_pc, inst_data} !== {1'b1, AW'(k), exp_w[k]})
        $display("FAIL arst_restart_%0d: got v=%b pc=%0d d=%h want v=1 pc=%0d d=%h",
                 k, inst_valid, inst_pc, inst_data, k, exp_w[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [AW+DW-1:0] head;
    logic             ev;
    logic [AW-1:0]    epc;
    logic [DW-1:0]    ed;
    fill_mem(25);
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      ev   = (mq.size() != 0);
      head = ev ? mq[0] : '0;
      epc  = head[AW+DW-1:DW];
      ed   = head[DW-1:0];
      n_checks++;
      if ({inst_valid, inst_pc, inst_data} !== {ev, epc, ed})
        $display("FAIL rand_head_c%0d: got v=%b pc=%0d d=%h want v=%b pc=%0d d=%h",
                 c, inst_valid, inst_pc, inst_data, ev, epc, ed);
      else n_pass++;
      n_checks++;
      if (imem_addr !== m_pc)
        $display("FAIL rand_addr_c%0d: got %0d want %0d", c, imem_addr, m_pc);
      else n_pass++;
      inst_ready     = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = AW'($urandom);
      tick();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    fill_mem(0);
    set_fixed();
    test_reset();
    test_stream();
    test_backpressure();
    test_jmp_fold();
    test_redirect_flush();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
